m_table_loader: RTL and testbench
=================================

Name: m_table_loader

Overview:
- Writer side of the Unsat_Clause_Selector 1/m table load interface.
- On a start pulse, computes the reciprocal entry for every m in 0..BUFFER_DEPTH with a bit-serial restoring divider.
- Streams each entry into the selector's table through setup / write address / data, gated by the selector's ready.
- Replaces the host-side $readmemh preload, so the table is built in-fabric after reset.

Parameters:
BUFFER_DEPTH, 2048, unsat buffer depth; table holds BUFFER_DEPTH+1 entries (m = 0..BUFFER_DEPTH)
M_TABLE_WIDTH, 32, reciprocal entry width W
ADDR_WIDTH, $clog2(BUFFER_DEPTH)+1, write address width; wide enough to reach BUFFER_DEPTH

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start_i  input  1  begin a full table load; sampled only in IDLE
wr_ready_i  input  1  selector ready; a write is accepted on a cycle with setup_o && wr_ready_i
setup_o  output  1  write valid / selector setup strobe
write_addr_o  output  ADDR_WIDTH  table address (= m)
mt_data_o  output  M_TABLE_WIDTH  reciprocal entry for write_addr_o
busy_o  output  1  load in progress
done_o  output  1  one-cycle pulse after the final write is accepted

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset).
- Reset values: setup_o=0, write_addr_o=0, mt_data_o=0, busy_o=0, done_o=0; state=IDLE; divider registers cleared.
- Entry value, W=M_TABLE_WIDTH:
  - m=0 -> 0
  - m=1 -> 2^W-1 (saturated)
  - m>=2 -> floor((2^W-1)/m)+1, i.e. ceil(2^W/m)
- Divider: restoring division of the all-ones W-bit dividend by zero-extended m.
  - One quotient bit per cycle, MSB first; W cycles per entry.
  - Remainder register is ADDR_WIDTH+1 bits.
  - Final +1 is a W-bit add; it cannot overflow for m>=2.
- States:
  - IDLE: busy_o=0. start_i=1 -> m=0, go WRITE.
  - CALC: m>=2 only, W cycles. Counter hits W-1 -> latch q+1 into mt_data_o, go WRITE.
  - WRITE: setup_o=1; write_addr_o and mt_data_o held stable until accepted.
    - wr_ready_i=0 -> hold.
    - Accepted and m==BUFFER_DEPTH -> DONE.
    - Otherwise m++; next m<=1 -> WRITE with direct value; else CALC.
  - DONE: setup_o=0, busy_o=0, done_o=1 for exactly one cycle -> IDLE.
- busy_o=1 in CALC and WRITE.
- Latency:
  - start_i sampled at edge k -> setup_o=1 with addr 0 from cycle k+1.
  - m=0 and m=1 each take one WRITE cycle.
  - Each m>=2 takes W CALC cycles + 1 WRITE cycle.
  - With wr_ready_i held high, busy lasts 2+(BUFFER_DEPTH-1)*(W+1) cycles, then done_o.
- start_i while busy or in DONE: ignored, no restart.
- wr_ready_i low during CALC: no effect; only WRITE waits on it.
- reset mid-load: IDLE next cycle, setup_o low, no partial-write completion; a new start_i restarts from m=0.
- Addresses are written strictly ascending with no gaps or duplicates; no wrap past BUFFER_DEPTH.

Optional Feature:
- Macro: MT_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum_o [M_TABLE_WIDTH-1:0].
  - Cleared on reset and on an accepted start_i.
  - XOR-accumulates mt_data_o on every accepted write.
  - Valid and stable from the done_o cycle until the next start.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- BUFFER_DEPTH=8, W=32, wr_ready_i=1, start pulse -> 9 writes, addr 0..8, data 0, FFFFFFFF, 80000000, 55555556, 40000000, 33333334, 2AAAAAAB, 24924925, 20000000; done_o one pulse exactly 233 cycles after busy_o rises.
- Default params, full load -> addr 2048 data 00200000, addr 7 data 24924925; every entry satisfies d*m >= 2^32 and (d-1)*m < 2^32 for m>=2.
- wr_ready_i low for 5 cycles while addr 3 is presented -> setup_o, addr 3, data 55555556 held stable; total load time grows by 5; no duplicate write.
- start_i re-pulsed mid-load at addr 4 -> ignored; addr sequence continues 5..8; single done_o.
- reset asserted during CALC for m=5 -> next cycle setup_o=0, busy_o=0; new start_i writes addr 0 first with data 0.
- MT_LOADER_CHECKSUM_EN, BUFFER_DEPTH=8 -> checksum_o equals the XOR of the nine listed values at the done_o cycle.

Source files
------------

// File: rtl/m_table_loader.sv
// -----------------------------------------------------------------------------
// m_table_loader
//
// Builds the 1/m reciprocal table of the unsat-clause selector inside the
// fabric. After a start pulse it walks m = 0..BUFFER_DEPTH in order, computes
// each entry and streams it to the selector one write at a time.
//
// Entry value for m (W = M_TABLE_WIDTH):
//   m = 0  -> 0
//   m = 1  -> 2^W-1 (saturated)
//   m >= 2 -> floor((2^W-1)/m) + 1  ( = ceil(2^W/m) )
// The quotient comes from a bit-serial restoring divider, one quotient bit
// per clock, MSB first, so every m >= 2 costs W cycles before its write.
//
// Write handshake: setup_o is the valid. A write is accepted on any rising
// edge where setup_o && wr_ready_i. While setup_o is high and the write has
// not been accepted, write_addr_o and mt_data_o do not change. setup_o never
// drops without an accepted write, except on reset.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   start_i       begin a full table load (only looked at while idle)
//   wr_ready_i    selector ready
//   setup_o       write valid / selector setup strobe
//   write_addr_o  table address (= m)
//   mt_data_o     reciprocal entry for write_addr_o
//   busy_o        load in progress (computing or writing)
//   done_o        one-cycle pulse after the final write is accepted
//   checksum_o    (MT_LOADER_CHECKSUM_EN only) XOR of all accepted entries
//
// Optional feature macro: MT_LOADER_CHECKSUM_EN
//   Adds checksum_o, cleared on reset and on an accepted start, XOR-updated
//   with mt_data_o on every accepted write, stable from done_o until the next
//   start. Without the macro the port and its logic are absent.
//
// The FSM state is held in the signal "state" for observation.
// -----------------------------------------------------------------------------
module m_table_loader #(
   parameter int BUFFER_DEPTH  = 2048,
   parameter int M_TABLE_WIDTH = 32,
   parameter int ADDR_WIDTH    = $clog2(BUFFER_DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start_i,
   input  logic                     wr_ready_i,
   output logic                     setup_o,
   output logic [ADDR_WIDTH-1:0]    write_addr_o,
   output logic [M_TABLE_WIDTH-1:0] mt_data_o,
   output logic                     busy_o,
   output logic                     done_o
`ifdef MT_LOADER_CHECKSUM_EN
   ,
   output logic [M_TABLE_WIDTH-1:0] checksum_o
`endif
);

   localparam int CNT_W = (M_TABLE_WIDTH > 1) ? $clog2(M_TABLE_WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;

   // Divider registers. The remainder is always < m <= BUFFER_DEPTH, so
   // after the left shift it still fits in ADDR_WIDTH+1 bits.
   logic [ADDR_WIDTH:0]        rem;
   logic [M_TABLE_WIDTH-1:0]   quo;
   logic [CNT_W-1:0]           cnt;

   logic [ADDR_WIDTH:0]        divisor;
   logic [ADDR_WIDTH:0]        rem_shift;
   logic [ADDR_WIDTH:0]        rem_next;
   logic                       q_bit;
   logic [M_TABLE_WIDTH-1:0]   quo_next;
   logic [ADDR_WIDTH-1:0]      m_next;
   logic                       accept;
   logic                       last_m;
   logic                       last_bit;

   // One restoring-division step. The dividend is all ones, so the bit
   // brought down into the remainder is always 1.
   always_comb begin
      divisor   = {1'b0, write_addr_o};
      rem_shift = {rem[ADDR_WIDTH-1:0], 1'b1};
      q_bit     = (rem_shift >= divisor);
      rem_next  = q_bit ? (rem_shift - divisor) : rem_shift;
      quo_next  = {quo[M_TABLE_WIDTH-2:0], q_bit};
      m_next    = write_addr_o + ADDR_WIDTH'(1);
      accept    = setup_o && wr_ready_i;
      last_m    = (write_addr_o == ADDR_WIDTH'(BUFFER_DEPTH));
      last_bit  = (cnt == CNT_W'(M_TABLE_WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         setup_o      <= 1'b0;
         write_addr_o <= '0;
         mt_data_o    <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         rem          <= '0;
         quo          <= '0;
         cnt          <= '0;
`ifdef MT_LOADER_CHECKSUM_EN
         checksum_o   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done_o <= 1'b0;
               if (start_i) begin
                  // m = 0 needs no division; present it immediately.
                  state        <= WRITE;
                  setup_o      <= 1'b1;
                  busy_o       <= 1'b1;
                  write_addr_o <= '0;
                  mt_data_o    <= '0;
`ifdef MT_LOADER_CHECKSUM_EN
                  checksum_o   <= '0;
`endif
               end
            end

            CALC: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt + CNT_W'(1);
               if (last_bit) begin
                  // Cannot overflow: for m >= 2 the quotient is < 2^(W-1).
                  mt_data_o <= quo_next + M_TABLE_WIDTH'(1);
                  setup_o   <= 1'b1;
                  state     <= WRITE;
               end
            end

            WRITE: begin
               if (accept) begin
`ifdef MT_LOADER_CHECKSUM_EN
                  checksum_o <= checksum_o ^ mt_data_o;
`endif
                  if (last_m) begin
                     setup_o <= 1'b0;
                     busy_o  <= 1'b0;
                     done_o  <= 1'b1;
                     state   <= DONE;
                  end else begin
                     write_addr_o <= m_next;
                     if (m_next == ADDR_WIDTH'(1)) begin
                        // m = 1 saturates; stay in WRITE with setup_o high.
                        mt_data_o <= {M_TABLE_WIDTH{1'b1}};
                     end else begin
                        setup_o <= 1'b0;
                        rem     <= '0;
                        quo     <= '0;
                        cnt     <= '0;
                        state   <= CALC;
                     end
                  end
               end
            end

            DONE: begin
               done_o <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_m_table_loader.sv
// -----------------------------------------------------------------------------
// tb_m_table_loader
//
// Bench for m_table_loader with BUFFER_DEPTH=8, W=32. Expected entries come
// from a ceil(2^W/m) reference computed with 64-bit arithmetic. A negedge
// monitor records every accepted write, busy rise and done pulse; each test
// task compares those records against the reference.
// -----------------------------------------------------------------------------
module tb_m_table_loader;

   localparam int DEPTH = 8;
   localparam int W     = 32;
   localparam int AW    = $clog2(DEPTH) + 1;
   localparam int LOAD_CYCLES = 2 + (DEPTH - 1) * (W + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start_i = 1'b0;
   logic          wr_ready_i = 1'b1;
   logic          setup_o;
   logic [AW-1:0] write_addr_o;
   logic [W-1:0]  mt_data_o;
   logic          busy_o;
   logic          done_o;
`ifdef MT_LOADER_CHECKSUM_EN
   logic [W-1:0]  checksum_o;
`endif

   int errors = 0;
   int checks = 0;

   m_table_loader #(
      .BUFFER_DEPTH (DEPTH),
      .M_TABLE_WIDTH(W),
      .ADDR_WIDTH   (AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start_i),
      .wr_ready_i  (wr_ready_i),
      .setup_o     (setup_o),
      .write_addr_o(write_addr_o),
      .mt_data_o   (mt_data_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
`ifdef MT_LOADER_CHECKSUM_EN
      ,
      .checksum_o  (checksum_o)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- monitor ----------------
   int            cyc = 0;
   int            busy_rise_cyc = -1;
   int            done_cyc = -1;
   int            done_cnt = 0;
   logic          busy_q = 1'b0;
   logic [AW-1:0] got_addr_q[$];
   logic [W-1:0]  got_data_q[$];
   logic [W-1:0]  exp_q[$];

   always @(negedge clk) begin
      cyc++;
      if (busy_o && !busy_q) busy_rise_cyc = cyc;
      busy_q = busy_o;
      if (done_o) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (setup_o && wr_ready_i) begin
         got_addr_q.push_back(write_addr_o);
         got_data_q.push_back(mt_data_o);
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] ref_entry(input int m);
      longint unsigned two_w;
      longint unsigned r;
      two_w = 64'd1 << W;
      if (m == 0)      r = 0;
      else if (m == 1) r = two_w - 1;
      else             r = (two_w + longint'(m) - 1) / longint'(m);
      return r[W-1:0];
   endfunction

   task automatic build_exp();
      exp_q.delete();
      for (int m = 0; m <= DEPTH; m++) exp_q.push_back(ref_entry(m));
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_mon();
      got_addr_q.delete();
      got_data_q.delete();
      done_cnt      = 0;
      done_cyc      = -1;
      busy_rise_cyc = -1;
   endtask

   task automatic do_start();
      @(posedge clk); #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
   endtask

   // Returns at posedge+1 of the cycle where done_o is high.
   task automatic wait_done(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(posedge clk); #1;
         if (done_o) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      start_i = 1'b0;
      wr_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (setup_o !== 1'b0) begin errors++; $display("FAIL reset_setup got=%b want=0", setup_o); end
      checks++; if (write_addr_o !== '0) begin errors++; $display("FAIL reset_addr got=%0d want=0", write_addr_o); end
      checks++; if (mt_data_o !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", mt_data_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done_o); end
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy_o !== 1'b0 || setup_o !== 1'b0) begin errors++; $display("FAIL idle_no_start busy=%b setup=%b want 0/0", busy_o, setup_o); end
   endtask

   task automatic test_full_load();
      bit ok;
      logic [W-1:0] exp_sum;
      clear_mon();
      build_exp();
      wr_ready_i = 1'b1;
      do_start();
      wait_done(2000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_timeout got=no_done want=done"); end
      @(negedge clk); #1;
      checks++; if (got_addr_q.size() != DEPTH + 1) begin errors++; $display("FAIL full_count got=%0d want=%0d", got_addr_q.size(), DEPTH + 1); end
      for (int i = 0; i < got_addr_q.size() && i <= DEPTH; i++) begin
         checks++;
         if (got_addr_q[i] !== AW'(i) || got_data_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL full_entry%0d got=%0d:%h want=%0d:%h", i, got_addr_q[i], got_data_q[i], i, exp_q[i]);
         end
      end
      checks++; if (done_cyc - busy_rise_cyc != LOAD_CYCLES) begin errors++; $display("FAIL full_latency got=%0d want=%0d", done_cyc - busy_rise_cyc, LOAD_CYCLES); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_cnt got=%0d want=1", done_cnt); end
`ifdef MT_LOADER_CHECKSUM_EN
      exp_sum = '0;
      foreach (exp_q[i]) exp_sum ^= exp_q[i];
      checks++; if (checksum_o !== exp_sum) begin errors++; $display("FAIL checksum got=%h want=%h", checksum_o, exp_sum); end
`else
      exp_sum = '0;
`endif
      @(posedge clk); #1;
      checks++; if (done_o !== 1'b0 || busy_o !== 1'b0 || setup_o !== 1'b0) begin errors++; $display("FAIL after_done done=%b busy=%b setup=%b want 0/0/0", done_o, busy_o, setup_o); end
`ifdef MT_LOADER_CHECKSUM_EN
      repeat (3) @(posedge clk); #1;
      checks++; if (checksum_o !== exp_sum) begin errors++; $display("FAIL checksum_hold got=%h want=%h", checksum_o, exp_sum); end
`endif
   endtask

   task automatic test_stall();
      bit ok;
      bit found;
      clear_mon();
      build_exp();
      wr_ready_i = 1'b1;
      do_start();
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (setup_o && write_addr_o == AW'(3)) begin found = 1'b1; break; end
         @(posedge clk); #1;
      end
      checks++; if (!found) begin errors++; $display("FAIL stall_find got=no_addr3 want=addr3"); end
      wr_ready_i = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         checks++;
         if (setup_o !== 1'b1 || write_addr_o !== AW'(3) || mt_data_o !== ref_entry(3)) begin
            errors++;
            $display("FAIL stall_hold%0d got=%b:%0d:%h want=1:3:%h", s, setup_o, write_addr_o, mt_data_o, ref_entry(3));
         end
      end
      @(posedge clk); #1 wr_ready_i = 1'b1;
      wait_done(2000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got=no_done want=done"); end
      @(negedge clk); #1;
      checks++; if (got_addr_q.size() != DEPTH + 1) begin errors++; $display("FAIL stall_count got=%0d want=%0d", got_addr_q.size(), DEPTH + 1); end
      for (int i = 0; i < got_addr_q.size() && i <= DEPTH; i++) begin
         checks++;
         if (got_addr_q[i] !== AW'(i) || got_data_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL stall_entry%0d got=%0d:%h want=%0d:%h", i, got_addr_q[i], got_data_q[i], i, exp_q[i]);
         end
      end
      checks++; if (done_cyc - busy_rise_cyc != LOAD_CYCLES + 5) begin errors++; $display("FAIL stall_latency got=%0d want=%0d", done_cyc - busy_rise_cyc, LOAD_CYCLES + 5); end
   endtask

   task automatic test_restart_ignored();
      bit ok;
      bit found;
      clear_mon();
      build_exp();
      wr_ready_i = 1'b1;
      do_start();
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (setup_o && write_addr_o == AW'(4)) begin found = 1'b1; break; end
         @(posedge clk); #1;
      end
      checks++; if (!found) begin errors++; $display("FAIL restart_find got=no_addr4 want=addr4"); end
      start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      wait_done(2000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL restart_timeout got=no_done want=done"); end
      repeat (6) @(posedge clk);
      #1;
      checks++; if (got_addr_q.size() != DEPTH + 1) begin errors++; $display("FAIL restart_count got=%0d want=%0d", got_addr_q.size(), DEPTH + 1); end
      for (int i = 0; i < got_addr_q.size() && i <= DEPTH; i++) begin
         checks++;
         if (got_addr_q[i] !== AW'(i) || got_data_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL restart_entry%0d got=%0d:%h want=%0d:%h", i, got_addr_q[i], got_data_q[i], i, exp_q[i]);
         end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done_cnt got=%0d want=1", done_cnt); end
      checks++; if (done_cyc - busy_rise_cyc != LOAD_CYCLES) begin errors++; $display("FAIL restart_latency got=%0d want=%0d", done_cyc - busy_rise_cyc, LOAD_CYCLES); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL restart_idle got=%b want=0", busy_o); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit found;
      clear_mon();
      build_exp();
      wr_ready_i = 1'b1;
      do_start();
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (busy_o && !setup_o && write_addr_o == AW'(5)) begin found = 1'b1; break; end
         @(posedge clk); #1;
      end
      checks++; if (!found) begin errors++; $display("FAIL rmid_find got=no_calc5 want=calc5"); end
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (setup_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rmid_idle setup=%b busy=%b want 0/0", setup_o, busy_o); end
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL rmid_no_resume busy=%b done=%b want 0/0", busy_o, done_o); end
      clear_mon();
      do_start();
      wait_done(2000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout got=no_done want=done"); end
      @(negedge clk); #1;
      checks++; if (got_addr_q.size() != DEPTH + 1) begin errors++; $display("FAIL rmid_count got=%0d want=%0d", got_addr_q.size(), DEPTH + 1); end
      for (int i = 0; i < got_addr_q.size() && i <= DEPTH; i++) begin
         checks++;
         if (got_addr_q[i] !== AW'(i) || got_data_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rmid_entry%0d got=%0d:%h want=%0d:%h", i, got_addr_q[i], got_data_q[i], i, exp_q[i]);
         end
      end
   endtask

   task automatic test_random_backpressure();
      bit ok;
      longint unsigned d;
      longint unsigned two_w;
      two_w = 64'd1 << W;
      clear_mon();
      build_exp();
      do_start();
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         if (done_o) begin ok = 1'b1; break; end
         wr_ready_i = ($urandom_range(0, 3) != 0);
      end
      wr_ready_i = 1'b1;
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout got=no_done want=done"); end
      @(negedge clk); #1;
      checks++; if (got_addr_q.size() != DEPTH + 1) begin errors++; $display("FAIL rand_count got=%0d want=%0d", got_addr_q.size(), DEPTH + 1); end
      for (int i = 0; i < got_addr_q.size() && i <= DEPTH; i++) begin
         checks++;
         if (got_addr_q[i] !== AW'(i) || got_data_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand_entry%0d got=%0d:%h want=%0d:%h", i, got_addr_q[i], got_data_q[i], i, exp_q[i]);
         end
         if (i >= 2) begin
            d = longint'(got_data_q[i]);
            checks++;
            if (!(d * longint'(i) >= two_w && (d - 1) * longint'(i) < two_w)) begin
               errors++;
               $display("FAIL rand_bounds%0d got=%h want=ceil(2^W/m)", i, got_data_q[i]);
            end
         end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand_done_cnt got=%0d want=1", done_cnt); end
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_stall();
      test_restart_ignored();
      test_reset_mid();
      for (int r = 0; r < 3; r++) test_random_backpressure();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
